accum_wr_ctrl: RTL and testbench

- Fill-side controller for the SYS_ROW-banked accumulator buffer. The skewed read controller drains this same buffer into the systolic array.
- Accepts a valid/ready stream of full rows (one element per bank) and writes row r to address r of every bank.
- Counts rows up to an effective length, then pulses done. done drives the read controller's start input directly.

---
 rtl/accum_wr_ctrl.sv | 143 ++++++++++++++
 tb/tb_accum_wr_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_wr_ctrl.sv
// Fill-side controller for the banked accumulator buffer: writes row r of an input stream to address r of every bank.
// Optional zero-fill of the unused tail rows is compiled in with ACCUM_WR_ZERO_FILL_EN.
module accum_wr_ctrl #(
    parameter int SYS_ROW    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ACCUM_ROW  = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         num_row,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SYS_ROW*DATA_WIDTH-1:0] in_data,
    output logic [SYS_ROW-1:0]            wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [SYS_ROW*DATA_WIDTH-1:0] wr_data,
    output logic                          busy,
    output logic                          done
);

    localparam int CNT_W = $clog2(ACCUM_ROW) + 1;
    localparam int CMP_W = (DATA_WIDTH > CNT_W) ? DATA_WIDTH : CNT_W;
    localparam logic [CNT_W-1:0] ROWS = CNT_W'(ACCUM_ROW);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
`ifdef ACCUM_WR_ZERO_FILL_EN
        ZFILL,
`endif
        FLUSH,
        DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [CNT_W-1:0]              eff_q, eff_d;
    logic [SYS_ROW-1:0]            wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
    logic [SYS_ROW*DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic [CMP_W-1:0] num_ext;
    logic [CNT_W-1:0] eff_start;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    // Compare at the wider of the two widths so num_row is never truncated before clamping.
    always_comb begin
        num_ext   = CMP_W'(num_row);
        eff_start = (num_ext > CMP_W'(ACCUM_ROW)) ? ROWS : CNT_W'(num_ext);
        cnt_inc   = cnt_q + CNT_W'(1);
        accept    = in_valid & in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            eff_q     <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            eff_q     <= eff_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        eff_d     = eff_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    eff_d = eff_start;
                    cnt_d = '0;
                    if (eff_start != '0) begin
                        state_d = FILL;
                    end else begin
`ifdef ACCUM_WR_ZERO_FILL_EN
                        state_d = ZFILL;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en_d   = '1;
                    wr_addr_d = ADDR_WIDTH'(cnt_q);
                    wr_data_d = in_data;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == eff_q) begin
`ifdef ACCUM_WR_ZERO_FILL_EN
                        state_d = (eff_q < ROWS) ? ZFILL : FLUSH;
`else
                        state_d = FLUSH;
`endif
                    end
                end
            end
`ifdef ACCUM_WR_ZERO_FILL_EN
            ZFILL: begin
                wr_en_d   = '1;
                wr_addr_d = ADDR_WIDTH'(cnt_q);
                wr_data_d = '0;
                cnt_d     = cnt_inc;
                if (cnt_inc == ROWS) begin
                    state_d = FLUSH;
                end
            end
`endif
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == FILL) && (cnt_q < eff_q);
        done     = (state_q == DONE);
`ifdef ACCUM_WR_ZERO_FILL_EN
        busy     = (state_q == FILL) || (state_q == ZFILL) || (state_q == FLUSH);
`else
        busy     = (state_q == FILL) || (state_q == FLUSH);
`endif
        wr_en    = wr_en_q;
        wr_addr  = wr_addr_q;
        wr_data  = wr_data_q;
    end

endmodule

// File: tb/tb_accum_wr_ctrl.sv
// Scoreboard bench for accum_wr_ctrl: the driver derives the expected write/done schedule
// of each fill from the row-count rules; a negedge monitor pops and compares.
module tb_accum_wr_ctrl;

    localparam int SR = 4;
    localparam int DW = 16;
    localparam int AR = 8;
    localparam int AW = 3;
`ifdef ACCUM_WR_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    typedef struct {
        int              cyc;
        int unsigned     addr;
        logic [SR*DW-1:0] data;
    } wr_t;

    logic                clk;
    logic                rst;
    logic                start;
    logic [DW-1:0]       num_row;
    logic                in_valid;
    logic                in_ready;
    logic [SR*DW-1:0]    in_data;
    logic [SR-1:0]       wr_en;
    logic [AW-1:0]       wr_addr;
    logic [SR*DW-1:0]    wr_data;
    logic                busy;
    logic                done;

    wr_t         wq[$];
    int          dq[$];
    bit          m_busy;
    bit          m_ready;
    int          cyc;
    int unsigned n_vec;
    int unsigned n_err;

    accum_wr_ctrl #(
        .SYS_ROW   (SR),
        .DATA_WIDTH(DW),
        .ACCUM_ROW (AR),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .num_row (num_row),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic logic [SR*DW-1:0] rand_row();
        logic [SR*DW-1:0] r;
        for (int unsigned i = 0; i < SR; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        wr_t e;
        int  d;
        check("busy", 64'(busy), 64'(m_busy));
        check("in_ready", 64'(in_ready), 64'(m_ready));
        if (wr_en != '0) begin
            if (wq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_write: got wr_en=%0h addr=%0d at cycle %0d, expected no write", wr_en, wr_addr, cyc);
            end else begin
                e = wq.pop_front();
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
                check("wr_en", 64'(wr_en), 64'({SR{1'b1}}));
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
            end
        end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
            e = wq.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missed_write: got no write, expected addr %0d at cycle %0d", e.addr, e.cyc);
        end
        if (done !== 1'b0) begin
            if (dq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                d = dq.pop_front();
                check("done_cycle", 64'(cyc), 64'(d));
            end
        end else if (dq.size() > 0 && dq[0] <= cyc) begin
            d = dq.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missed_done: got done=0, expected pulse at cycle %0d", d);
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    // One fill: n rows requested, gap_pct chance of idle input per cycle,
    // abort_rel != 0 asserts reset that many cycles after start.
    task automatic run_fill(input int unsigned n, input int unsigned gap_pct,
                            input int unsigned abort_rel, input bit noise_start);
        int               t;
        int               c;
        int               eff;
        int               acc;
        int               last;
        int               nz;
        int               first_w;
        int               done_cyc;
        logic [SR*DW-1:0] beat;
        eff      = (n < AR) ? int'(n) : AR;
        t        = cyc;
        start    = 1'b1;
        num_row  = DW'(n);
        in_valid = 1'b0;
        m_busy   = 1'b0;
        m_ready  = 1'b0;
        beat     = rand_row();
        acc      = 0;
        last     = t;
        while (acc < eff) begin
            tick();
            c        = cyc;
            start    = noise_start && ($urandom_range(3) == 0);
            num_row  = DW'($urandom);
            m_busy   = 1'b1;
            m_ready  = 1'b1;
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = beat;
            if (abort_rel != 0 && c == t + int'(abort_rel)) begin
                #1 rst = 1'b1;
                #1;
                check_outputs_zero("abort");
                while (wq.size() > 0 && wq[wq.size()-1].cyc >= c) void'(wq.pop_back());
                m_busy   = 1'b0;
                m_ready  = 1'b0;
                in_valid = 1'b0;
                start    = 1'b0;
                tick();
                tick();
                rst = 1'b0;
                tick();
                check("abort_wq_empty", 64'(wq.size()), 64'd0);
                return;
            end
            if (in_valid) begin
                wq.push_back('{c + 1, acc, beat});
                acc++;
                last = c;
                beat = rand_row();
            end
        end
        nz      = ZF ? AR - eff : 0;
        first_w = (eff > 0) ? last + 2 : t + 2;
        for (int k = 0; k < nz; k++) wq.push_back('{first_w + k, eff + k, '0});
        if (nz > 0)       done_cyc = first_w + nz;
        else if (eff > 0) done_cyc = last + 2;
        else              done_cyc = t + 1;
        dq.push_back(done_cyc);
        while (cyc < done_cyc) begin
            tick();
            m_ready  = 1'b0;
            m_busy   = (cyc < done_cyc);
            in_valid = ($urandom_range(1) == 1);
            in_data  = rand_row();
            if (cyc == done_cyc) begin
                start   = 1'b1;
                num_row = DW'(1);
            end else begin
                start   = noise_start && ($urandom_range(3) == 0);
                num_row = DW'($urandom);
            end
        end
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        m_busy   = 1'b0;
        tick();
        check("wq_drained", 64'(wq.size()), 64'd0);
        check("dq_drained", 64'(dq.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_busy   = 1'b0;
        m_ready  = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        num_row  = '0;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        check_outputs_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_fill(4, 0, 0, 1'b0);
        run_fill(3, 50, 0, 1'b0);
        run_fill(20, 20, 0, 1'b0);
        run_fill(0, 0, 0, 1'b0);
        run_fill(5, 0, 4, 1'b0);
        run_fill(1, 0, 0, 1'b0);
        run_fill(6, 30, 0, 1'b1);
        run_fill(AR, 0, 0, 1'b0);
        run_fill(AR - 1, 10, 0, 1'b1);
        run_fill(AR + 1, 0, 0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            run_fill($urandom_range(12), $urandom_range(60), 0, 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
